// File: rtl/pu_msp430_dac_spi_master.sv
// pu_msp430_dac_spi_master: two-channel arbitrated SPI master feeding a 16-bit-frame DAC.
//   mclk, puc_rst             : clock, synchronous active-high reset
//   ch0/1_req, ch0/1_data     : level requests held until ack, 12-bit codes captured at grant
//   ch0/1_ack                 : one-cycle pulse once the frame has been latched by the DAC
//   busy, last_ch             : engine active, most recently granted channel
//   dac_sclk/dac_din/dac_sync_n : SPI pins (sclk idles low, DAC samples din on falling sclk)
//   PU_MSP430_DAC_SPI_MASTER_RR_EN : round-robin arbitration; fixed ch0 priority when undefined
module pu_msp430_dac_spi_master #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        ch0_req,
  input  logic        ch1_req,
  input  logic [11:0] ch0_data,
  input  logic [11:0] ch1_data,
  output logic        ch0_ack,
  output logic        ch1_ack,
  output logic        busy,
  output logic        last_ch,
  output logic        dac_sclk,
  output logic        dac_din,
  output logic        dac_sync_n
);
  typedef enum logic [2:0] {IDLE, ARB, SYNC, SHIFT, LSETUP, LPULSE, DONE, GAP} state_t;
  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LD = 8'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  state_t      state_q;
  logic [7:0]  div_q, gap_q;
  logic [3:0]  bit_q;
  logic [15:0] frame_q, frame_d;
  logic        gnt_d, ch_q, last_ch_q, ack0_q, ack1_q, busy_q, sclk_q, din_q, sync_n_q, div_end;
`ifdef PU_MSP430_DAC_SPI_MASTER_RR_EN
  assign gnt_d = (ch0_req & ch1_req) ? ~last_ch_q : ch1_req;
`else
  assign gnt_d = ch1_req & ~ch0_req;
`endif
  assign frame_d = {3'b000, gnt_d, gnt_d ? ch1_data : ch0_data};
  assign div_end = div_q == 8'd0;
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      gap_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      ch_q      <= 1'b0;
      last_ch_q <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      din_q     <= 1'b0;
      sync_n_q  <= 1'b1;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      // every timed phase is exactly CLK_DIV cycles, so expiry is always a phase change
      if (state_q inside {SYNC, SHIFT, LSETUP, LPULSE}) div_q <= div_end ? DIV_LD : div_q - 8'd1;
      case (state_q)
        IDLE: if (ch0_req | ch1_req) begin
          busy_q  <= 1'b1;
          state_q <= ARB;
        end
        ARB: begin
          frame_q   <= frame_d;
          ch_q      <= gnt_d;
          last_ch_q <= gnt_d;
          din_q     <= frame_d[15];
          sync_n_q  <= 1'b0;
          div_q     <= DIV_LD;
          state_q   <= SYNC;
        end
        SYNC: if (div_end) begin
          sclk_q  <= 1'b1;
          bit_q   <= 4'd15;
          state_q <= SHIFT;
        end
        SHIFT: if (div_end) begin
          if (sclk_q) sclk_q <= 1'b0;
          else if (bit_q == 4'd0) begin
            sync_n_q <= 1'b1;
            state_q  <= LSETUP;
          end else begin
            // next bit appears together with the rising edge, never on the falling one
            sclk_q <= 1'b1;
            din_q  <= frame_q[bit_q - 4'd1];
            bit_q  <= bit_q - 4'd1;
          end
        end
        LSETUP: if (div_end) begin
          sclk_q  <= 1'b1;
          state_q <= LPULSE;
        end
        LPULSE: if (div_end) begin
          if (sclk_q) sclk_q <= 1'b0;
          else begin
            ack0_q  <= ~ch_q;
            ack1_q  <= ch_q;
            state_q <= DONE;
          end
        end
        DONE: if (GAP_CYC == 0) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          gap_q   <= GAP_LD;
          state_q <= GAP;
        end
        GAP: if (gap_q == 8'd0) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else gap_q <= gap_q - 8'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ch0_ack    = ack0_q;
  assign ch1_ack    = ack1_q;
  assign busy       = busy_q;
  assign last_ch    = last_ch_q;
  assign dac_sclk   = sclk_q;
  assign dac_din    = din_q;
  assign dac_sync_n = sync_n_q;
endmodule
